// File: rtl/decode_stage.sv
// Decode stage: register-address decode, register file with link write port
// and write-to-read bypass, immediate extension, and the D/E pipeline register.
module decode_stage #(
  parameter int WIDTH      = 64,  // data/instruction width, at least 64
  parameter int AW         = 5,   // register address width
  parameter int RA1_LSB    = 47,
  parameter int RA2_LSB    = 0,
  parameter int RA2ALT_LSB = 42
) (
  input  logic             clk,
  input  logic             reset,        // asynchronous, active low
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             ValidD,
  input  logic [WIDTH-1:0] InstructionD,
  input  logic [WIDTH-1:0] PCPlus8D,
  input  logic [1:0]       ImmSrcD,
  input  logic [1:0]       RegSrcD,
  input  logic             RegWriteW,
  input  logic             LinkWriteW,
  input  logic [AW-1:0]    WA3W,
  input  logic [WIDTH-1:0] ResultW,
  output logic [AW-1:0]    RA1D,
  output logic [AW-1:0]    RA2D,
  output logic [WIDTH-1:0] RD1E,
  output logic [WIDTH-1:0] RD2E,
  output logic [WIDTH-1:0] ExtImmE,
  output logic [AW-1:0]    RA1E,
  output logic [AW-1:0]    RA2E,
  output logic             ValidE
);

  localparam int            NREG      = 2**AW;
  localparam logic [AW-1:0] LINK_ADDR = '1;

  logic [WIDTH-1:0] r_regs [NREG];

  logic [AW-1:0]    w_ra1;
  logic [AW-1:0]    w_ra2;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;
  logic [WIDTH-1:0] w_ext_imm;

  logic [WIDTH-1:0] r_rd1e;
  logic [WIDTH-1:0] r_rd2e;
  logic [WIDTH-1:0] r_ext_imm_e;
  logic [AW-1:0]    r_ra1e;
  logic [AW-1:0]    r_ra2e;
  logic             r_valid_e;

  // Only a few instruction fields are decoded here; the rest belong to later stages.
  logic w_unused;
  assign w_unused = ^InstructionD;

  // Register-address decode; RegSrcD[0] forces the link register onto port 1.
  always_comb begin
    w_ra1 = RegSrcD[0] ? LINK_ADDR : InstructionD[RA1_LSB +: AW];
    w_ra2 = RegSrcD[1] ? InstructionD[RA2ALT_LSB +: AW] : InstructionD[RA2_LSB +: AW];
  end

  assign RA1D = w_ra1;
  assign RA2D = w_ra2;

  // Register-file write ports; a writeback to the link register overrides the link write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the register file is small and must read as zero after reset, so it is
      // reset like any other flop rather than left as an uninitialised memory.
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      // NOTE: both writes may target the same entry; with non-blocking assignments the
      // later statement takes effect, which gives ResultW priority over PCPlus8D.
      if (LinkWriteW) r_regs[LINK_ADDR] <= PCPlus8D;
      if (RegWriteW)  r_regs[WA3W]      <= ResultW;
    end
  end

  // Read ports with same-cycle bypass: writeback data first, then link data, then storage.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    w_rd1 = r_regs[w_ra1];
    w_rd2 = r_regs[w_ra2];
    if (RegWriteW && (WA3W == w_ra1))             w_rd1 = ResultW;
    else if (LinkWriteW && (w_ra1 == LINK_ADDR))  w_rd1 = PCPlus8D;
    if (RegWriteW && (WA3W == w_ra2))             w_rd2 = ResultW;
    else if (LinkWriteW && (w_ra2 == LINK_ADDR))  w_rd2 = PCPlus8D;
  end

  // Immediate extension from the low 24 instruction bits.
  always_comb begin
    w_ext_imm = '0;
    case (ImmSrcD)
      2'b00:   w_ext_imm = {{(WIDTH-8){1'b0}}, InstructionD[7:0]};
      2'b01:   w_ext_imm = {{(WIDTH-12){1'b0}}, InstructionD[11:0]};
      2'b10:   w_ext_imm = {{(WIDTH-26){InstructionD[23]}}, InstructionD[23:0], 2'b00};
      default: w_ext_imm = {{(WIDTH-24){InstructionD[23]}}, InstructionD[23:0]};
    endcase
  end

  // D/E pipeline register: flush beats stall; invalid instructions are captured as-is.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd1e      <= '0;
      r_rd2e      <= '0;
      r_ext_imm_e <= '0;
      r_ra1e      <= '0;
      r_ra2e      <= '0;
      r_valid_e   <= 1'b0;
    end else if (FlushD) begin
      r_rd1e      <= '0;
      r_rd2e      <= '0;
      r_ext_imm_e <= '0;
      r_ra1e      <= '0;
      r_ra2e      <= '0;
      r_valid_e   <= 1'b0;
    end else if (!StallD) begin
      r_rd1e      <= w_rd1;
      r_rd2e      <= w_rd2;
      r_ext_imm_e <= w_ext_imm;
      r_ra1e      <= w_ra1;
      r_ra2e      <= w_ra2;
      r_valid_e   <= ValidD;
    end
  end

  assign RD1E    = r_rd1e;
  assign RD2E    = r_rd2e;
  assign ExtImmE = r_ext_imm_e;
  assign RA1E    = r_ra1e;
  assign RA2E    = r_ra2e;
  assign ValidE  = r_valid_e;

endmodule
